// File: rtl/bus_pkg.sv
// Shared defaults and helpers for the round-robin bus interconnect.
package bus_pkg;

    localparam int unsigned DEF_N_MASTER = 2;
    localparam int unsigned DEF_N_SLAVE  = 4;
    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_DATA_W   = 32;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // Ceiling log2, never below 1 so index vectors always have a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/bus_rr_matrix_if.sv
// Bundle of master-side and slave-side bus signals around the interconnect.
interface bus_rr_matrix_if
    import bus_pkg::*;
#(
    parameter int unsigned N_MASTER = DEF_N_MASTER,
    parameter int unsigned N_SLAVE  = DEF_N_SLAVE,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W
);
    logic [N_MASTER-1:0]        M_req;
    logic [N_MASTER-1:0]        M_wr;
    logic [N_MASTER*ADDR_W-1:0] M_address;
    logic [N_MASTER*DATA_W-1:0] M_dout;
    logic [N_SLAVE*DATA_W-1:0]  S_dout;
    logic [N_MASTER-1:0]        M_grant;
    logic [DATA_W-1:0]          M_din;
    logic [N_SLAVE-1:0]         S_sel;
    logic [ADDR_W-1:0]          S_address;
    logic                       S_wr;
    logic [DATA_W-1:0]          S_din;
    logic                       dec_err;

    // Interconnect view.
    modport slave (
        input  M_req, M_wr, M_address, M_dout, S_dout,
        output M_grant, M_din, S_sel, S_address, S_wr, S_din, dec_err
    );

    // Agent view: masters and slave memories around the interconnect.
    modport master (
        output M_req, M_wr, M_address, M_dout, S_dout,
        input  M_grant, M_din, S_sel, S_address, S_wr, S_din, dec_err
    );
endinterface

// File: rtl/bus_rr_arbit.sv
// Registered round-robin arbiter with optional hold limit.
module bus_rr_arbit
    import bus_pkg::*;
#(
    parameter int unsigned N_MASTER = DEF_N_MASTER,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_MASTER-1:0] req,
    output logic [N_MASTER-1:0] grant
);
    localparam int unsigned OWN_W  = clog2(N_MASTER);
    localparam int unsigned HOLD_W = clog2((MAX_HOLD > 1) ? MAX_HOLD : 2);

    arb_state_e          state_q, state_d;
    logic [OWN_W-1:0]    last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [N_MASTER-1:0] grant_q, grant_d;
    logic                rr_found;
    logic [OWN_W-1:0]    rr_idx;
    logic                others;
    int unsigned         cand;

    // Round-robin search starting just after the last owner.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_q;
        cand     = 0;
        for (int unsigned j = 1; j <= N_MASTER; j++) begin
            cand = 32'(last_q) + j;
            if (cand >= N_MASTER) cand = cand - N_MASTER;
            if (!rr_found && req[OWN_W'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = OWN_W'(cand);
            end
        end
        others = |(req & ~grant_q);
    end

    // Next-state: grant, owner and hold counter.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (rr_found) begin
                    state_d = ARB_OWNED;
                    last_d  = rr_idx;
                    hold_d  = '0;
                    grant_d = N_MASTER'(1) << rr_idx;
                end
            end
            ARB_OWNED: begin
                if (req[last_q]) begin
                    if (MAX_HOLD != 0 && hold_q == HOLD_W'(MAX_HOLD - 1) && others) begin
                        last_d  = rr_idx;
                        hold_d  = '0;
                        grant_d = N_MASTER'(1) << rr_idx;
                    end else if (MAX_HOLD > 1 && hold_q != HOLD_W'(MAX_HOLD - 1)) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else if (rr_found) begin
                    last_d  = rr_idx;
                    hold_d  = '0;
                    grant_d = N_MASTER'(1) << rr_idx;
                end else begin
                    state_d = ARB_IDLE;
                    hold_d  = '0;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Arbiter state registers; master 0 wins first after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            last_q  <= OWN_W'(N_MASTER - 1);
            hold_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: rtl/bus_rr_matrix.sv
// Shared-bus interconnect: RR arbitration, owner routing, slave decode, read return.
module bus_rr_matrix
    import bus_pkg::*;
#(
    parameter int unsigned N_MASTER = DEF_N_MASTER,
    parameter int unsigned N_SLAVE  = DEF_N_SLAVE,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_HOLD = 0
) (
    input logic            clk,
    input logic            reset_n,
    bus_rr_matrix_if.slave bus
);
    localparam int unsigned SLV_IDX_W = clog2(N_SLAVE);

    logic [N_MASTER-1:0]  grant;
    logic [ADDR_W-1:0]    addr_c;
    logic                 wr_c;
    logic [DATA_W-1:0]    din_c;
    logic [SLV_IDX_W-1:0] idx_c;
    logic [N_SLAVE-1:0]   sel_c;
    logic                 unmapped_c;
    logic [N_SLAVE-1:0]   sel_q;
    logic                 dec_err_q;
    logic [DATA_W-1:0]    rdata_c;

    bus_rr_arbit #(
        .N_MASTER (N_MASTER),
        .MAX_HOLD (MAX_HOLD)
    ) u_arbit (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.M_req),
        .grant   (grant)
    );

    // Route the owner's request onto the bus and decode the slave index.
    always_comb begin
        addr_c     = '0;
        wr_c       = 1'b0;
        din_c      = '0;
        sel_c      = '0;
        unmapped_c = 1'b0;
        for (int unsigned i = 0; i < N_MASTER; i++) begin
            if (grant[i]) begin
                addr_c = bus.M_address[i*ADDR_W +: ADDR_W];
                wr_c   = bus.M_wr[i];
                din_c  = bus.M_dout[i*DATA_W +: DATA_W];
            end
        end
        idx_c = addr_c[ADDR_W-1 -: SLV_IDX_W];
        if (|grant) begin
            if (32'(idx_c) < N_SLAVE) sel_c = N_SLAVE'(1) << idx_c;
            else                      unmapped_c = 1'b1;
        end
    end

    // Remember last cycle's select for read return and flag unmapped accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q     <= '0;
            dec_err_q <= 1'b0;
        end else begin
            sel_q     <= sel_c;
            dec_err_q <= unmapped_c;
        end
    end

    // Read data mux driven by the previous cycle's select.
    always_comb begin
        rdata_c = '0;
        for (int unsigned s = 0; s < N_SLAVE; s++) begin
            if (sel_q[s]) rdata_c = bus.S_dout[s*DATA_W +: DATA_W];
        end
    end

    assign bus.M_grant   = grant;
    assign bus.S_address = addr_c;
    assign bus.S_wr      = wr_c;
    assign bus.S_din     = din_c;
    assign bus.S_sel     = sel_c;
    assign bus.M_din     = rdata_c;
    assign bus.dec_err   = dec_err_q;

endmodule

// File: tb/tb_bus_rr_matrix.sv
// Scoreboard bench: two interconnect configs share master stimulus, checked against a queue-fed model.
module tb_bus_rr_matrix;

    typedef struct packed {
        logic [2:0]  grant;
        logic [3:0]  sel;
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] sdin;
        logic [31:0] mdin;
        logic        dec;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bus_rr_matrix_if #(.N_MASTER(3), .N_SLAVE(4), .ADDR_W(8), .DATA_W(32)) ifa ();
    bus_rr_matrix_if #(.N_MASTER(3), .N_SLAVE(3), .ADDR_W(8), .DATA_W(32)) ifb ();

    bus_rr_matrix #(.N_MASTER(3), .N_SLAVE(4), .ADDR_W(8), .DATA_W(32), .MAX_HOLD(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa));
    bus_rr_matrix #(.N_MASTER(3), .N_SLAVE(3), .ADDR_W(8), .DATA_W(32), .MAX_HOLD(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb));

    // stimulus state
    logic [2:0]  req, wr;
    logic [7:0]  addr [3];
    logic [31:0] dout [3];
    logic [31:0] sdo_a [4];
    logic [31:0] sdo_b [3];

    // reference model state: owner -1 = idle, selp -1 = nothing selected
    int owner [2];
    int last  [2];
    int hold  [2];
    int selp  [2];
    bit dec   [2];
    int ns    [2] = '{4, 3};
    int mh    [2] = '{0, 4};

    exp_t q_a[$];
    exp_t q_b[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    function automatic int rr_pick(input logic [2:0] r, input int l);
        for (int j = 1; j <= 3; j++) begin
            int c;
            c = (l + j) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; last[k] = 2; hold[k] = 0; selp[k] = -1; dec[k] = 1'b0;
        end
    endtask

    task automatic model_eval(input int k, output exp_t e);
        int idx;
        e = '0;
        if (owner[k] >= 0) begin
            e.grant[owner[k]] = 1'b1;
            e.addr = addr[owner[k]];
            e.wr   = wr[owner[k]];
            e.sdin = dout[owner[k]];
            idx = int'(addr[owner[k]]) / 64;
            if (idx < ns[k]) e.sel[idx] = 1'b1;
        end
        if (selp[k] >= 0) e.mdin = (k == 0) ? sdo_a[selp[k]] : sdo_b[selp[k]];
        e.dec = dec[k];
    endtask

    task automatic model_step(input int k);
        int idx, n;
        logic [2:0] oth;
        idx = (owner[k] >= 0) ? int'(addr[owner[k]]) / 64 : 0;
        selp[k] = (owner[k] >= 0 && idx < ns[k]) ? idx : -1;
        dec[k]  = (owner[k] >= 0 && idx >= ns[k]);
        if (owner[k] < 0) begin
            n = rr_pick(req, last[k]);
            if (n >= 0) begin owner[k] = n; last[k] = n; hold[k] = 0; end
        end else if (req[owner[k]]) begin
            oth = req;
            oth[owner[k]] = 1'b0;
            if (mh[k] != 0 && hold[k] == mh[k] - 1 && oth != 3'b000) begin
                n = rr_pick(req, owner[k]);
                owner[k] = n; last[k] = n; hold[k] = 0;
            end else if (mh[k] > 0 && hold[k] < mh[k] - 1) begin
                hold[k] = hold[k] + 1;
            end
        end else begin
            n = rr_pick(req, owner[k]);
            if (n >= 0) begin owner[k] = n; last[k] = n; end
            else owner[k] = -1;
            hold[k] = 0;
        end
    endtask

    // One bus cycle: drive inputs after the edge, predict outputs, advance model.
    task automatic apply(input logic rst);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n       = rst;
        ifa.M_req     = req;     ifb.M_req     = req;
        ifa.M_wr      = wr;      ifb.M_wr      = wr;
        ifa.M_address = {addr[2], addr[1], addr[0]};
        ifb.M_address = {addr[2], addr[1], addr[0]};
        ifa.M_dout    = {dout[2], dout[1], dout[0]};
        ifb.M_dout    = {dout[2], dout[1], dout[0]};
        ifa.S_dout    = {sdo_a[3], sdo_a[2], sdo_a[1], sdo_a[0]};
        ifb.S_dout    = {sdo_b[2], sdo_b[1], sdo_b[0]};
        if (!rst) model_reset();
        model_eval(0, e); q_a.push_back(e);
        model_eval(1, e); q_b.push_back(e);
        if (rst) begin
            model_step(0);
            model_step(1);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input exp_t a);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got grant=%h sel=%h addr=%h wr=%b sdin=%h mdin=%h dec=%b exp grant=%h sel=%h addr=%h wr=%b sdin=%h mdin=%h dec=%b",
                     tag, cyc, a.grant, a.sel, a.addr, a.wr, a.sdin, a.mdin, a.dec,
                     e.grant, e.sel, e.addr, e.wr, e.sdin, e.mdin, e.dec);
        end
    endtask

    // Monitor: pop predictions and compare mid-cycle.
    initial begin
        exp_t ea, eb, aa, ab;
        forever begin
            @(negedge clk);
            cyc++;
            if (q_a.size() > 0 && q_b.size() > 0) begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                aa = {ifa.M_grant, ifa.S_sel, ifa.S_address, ifa.S_wr, ifa.S_din, ifa.M_din, ifa.dec_err};
                ab = {ifb.M_grant, 1'b0, ifb.S_sel, ifb.S_address, ifb.S_wr, ifb.S_din, ifb.M_din, ifb.dec_err};
                compare("dut_a", ea, aa);
                compare("dut_b", eb, ab);
            end
        end
    end

    task automatic rand_sdo();
        for (int s = 0; s < 4; s++) sdo_a[s] = $urandom;
        for (int s = 0; s < 3; s++) sdo_b[s] = $urandom;
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0; wr = '0;
        for (int m = 0; m < 3; m++) begin addr[m] = '0; dout[m] = '0; end
        rand_sdo();
        model_reset();

        // reset, then idle
        apply(1'b0); apply(1'b0);
        apply(1'b1);
        // M0 writes 0x45 <- DEADBEEF
        req = 3'b001; wr = 3'b001; addr[0] = 8'h45; dout[0] = 32'hDEADBEEF;
        apply(1'b1); apply(1'b1);
        // M0 and M1 contend; M1 reads 0xC0
        req = 3'b011; addr[1] = 8'hC0; dout[1] = 32'h0BADF00D;
        repeat (10) begin rand_sdo(); apply(1'b1); end
        // M0 drops: direct handover to M1 reading slave 3
        req = 3'b010;
        sdo_a[3] = 32'h12345678;
        repeat (3) apply(1'b1);
        // reset while M1 owns mid-read, then both request
        req = 3'b011;
        apply(1'b0); apply(1'b0);
        repeat (4) begin rand_sdo(); apply(1'b1); end

        // randomized traffic with sticky requests and occasional reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)
                for (int m = 0; m < 3; m++) req[m] = ($urandom_range(0, 9) < 6);
            for (int m = 0; m < 3; m++) begin
                wr[m]   = 1'($urandom);
                addr[m] = 8'($urandom);
                dout[m] = $urandom;
            end
            rand_sdo();
            apply(($urandom_range(0, 299) != 0));
        end

        repeat (3) @(posedge clk);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d/%0d pending exp 0", q_a.size(), q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_rr_matrix.md
# bus_rr_matrix

Parametrised shared-bus interconnect: N_MASTER masters contend for one bus that fans out to N_SLAVE memory-mapped slaves. A registered round-robin arbiter with an optional hold limit grants ownership. The winner's write enable, address and write data are routed to the slaves. The slave-select one-hot is decoded from the address, and read data is returned to all masters one cycle later. It replaces the fixed two-master / four-slave bus between the master processors and the slave memories.

## Interface
- N_MASTER, 2: number of masters (2..8)
- N_SLAVE, 4: number of slaves (2..16); SLV_IDX_W = clog2(N_SLAVE), derived
- ADDR_W, 8: address width; slave index = address[ADDR_W-1 -: SLV_IDX_W]
- DATA_W, 32: data width
- MAX_HOLD, 0: maximum consecutive grant cycles while another master waits; 0 = unlimited
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- M_req  in  N_MASTER  per-master request
- M_wr  in  N_MASTER  per-master write (1) / read (0)
- M_address  in  N_MASTER*ADDR_W  packed, master i at [i*ADDR_W +: ADDR_W]
- M_dout  in  N_MASTER*DATA_W  packed master write data
- S_dout  in  N_SLAVE*DATA_W  packed slave read data
- M_grant  out  N_MASTER  one-hot or zero, registered
- M_din  out  DATA_W  read data to masters
- S_sel  out  N_SLAVE  one-hot or zero slave select
- S_address  out  ADDR_W  routed address
- S_wr  out  1  routed write enable
- S_din  out  DATA_W  routed write data
- dec_err  out  1  registered flag: previous bus cycle addressed an unmapped slave index

## Operation
- Arbiter states: IDLE (M_grant=0), OWNED(k) (M_grant=1<<k). Register last_owner; priority search starts at last_owner+1 mod N_MASTER.
- IDLE: any M_req → OWNED(first requester in RR order) on the next edge.
- OWNED(k), M_req[k]=1: stay. Exception: MAX_HOLD≠0, hold_cnt==MAX_HOLD-1, and another request pending → switch to next RR requester, hold_cnt=0.
- OWNED(k), M_req[k]=0: next RR requester if any (direct handover, no idle cycle), else IDLE.
- hold_cnt increments each OWNED cycle with the same owner and saturates at MAX_HOLD-1. It clears on any owner change or IDLE.
- Routing (combinational from registered grant): S_wr/S_address/S_din = owner's signals. With no grant: S_wr=0, S_address=0, S_din=0, S_sel=0.
- Decode: idx < N_SLAVE → S_sel = 1<<idx. Otherwise S_sel = 0, and an access flag is raised.
- sel_q <= S_sel each edge. M_din = S_dout slice selected by sel_q, or 0 when sel_q = 0.
- dec_err <= (grant active && idx >= N_SLAVE) each edge.

## Timing
- Reset values: M_grant=0, last_owner=N_MASTER-1 (master 0 wins first), hold_cnt=0, sel_q=0, dec_err=0. Hence S_sel=0, S_wr=0, S_address=0, S_din=0, M_din=0.
- Request-to-grant latency: 1 cycle (request sampled at edge t, grant visible after t).
- Write: the slave samples S_wr/S_din in the same cycle S_sel is asserted.
- Read: M_din is valid the cycle after S_sel/S_address were presented.
- Simultaneous requests: resolved purely by RR order, never by index.
- Owner drops its request while another master raises one on the same edge: handover to the RR winner in one edge.
- Reset asserted mid-transfer: all registers clear immediately (asynchronously), with no pending completion. The outputs above hold until reset_n rises; arbitration resumes on the first edge after release.

## Structure
- Shared package bus_pkg: default ADDR_W, DATA_W, N_MASTER, N_SLAVE, and the clog2 helper.
- Sub-module bus_rr_arbit: contains last_owner, hold_cnt and the grant register. Its inputs are M_req; its output is M_grant.
- Routing, decode, sel_q and dec_err sit in the top module.

## Test plan
- Reset, then M_req=01: M_grant=01 after 1 edge. M0 writes addr 0x45, data 0xDEADBEEF → S_sel=0010, S_wr=1, S_din=0xDEADBEEF.
- M_req=11 held constant, MAX_HOLD=0: M0 keeps the grant indefinitely. Drop M_req[0] → M_grant=10 on the next edge, no idle cycle.
- MAX_HOLD=4, both masters requesting continuously: grant alternates 01,01,01,01,10,10,10,10,01…
- Read from addr 0xC0 with S_dout slave 3 = 0x12345678: M_din=0x12345678 exactly one cycle after S_sel=1000. M_din=0 when no select preceded.
- N_SLAVE=3, access to addr 0xC0: S_sel=000, dec_err=1 one cycle later, M_din=0.
- Assert reset_n=0 while M1 owns the bus mid-read: M_grant, S_sel, M_din and dec_err go to 0 immediately. After release with M_req=11, M0 is granted first.
